cpu_bus_sequencer: RTL
======================

# cpu_bus_sequencer

Parametrised M-cycle sequencer and system-bus interface for the SM83 core. It replaces the CPU's free-running 2-bit T-cycle counter and its hard-wired `t_cycle == 3` commit. It adds wait states, a bus timeout, a double-speed mode and a HALT/STOP sleep state. It sits between `cpu_control`/datapath and the system bus, and generates the commit strobe that gates all register writeback.

## Interface

**Parameters**
- `ADDR_W`, default 16: bus address width.
- `DATA_W`, default 8: bus data width.
- `T_PER_M`, default 4: T-cycles per M-cycle in normal speed. Must be even and ≥ 4.
- `MAX_WAIT`, default 15: maximum wait-state clocks before timeout. Must be ≥ 1.

**Ports**
- `clk` input 1: core clock. One clock is one T-cycle.
- `reset` input 1: synchronous, active-high reset.
- `double_speed` input 1: 1 selects M-cycle length `T_PER_M/2`.
- `cpu_req` input 1: current M-cycle performs a bus access.
- `cpu_write` input 1: the access is a write.
- `cpu_addr` input `ADDR_W`: access address.
- `cpu_wdata` input `DATA_W`: write data.
- `cpu_rdata` output `DATA_W`: read data to the datapath.
- `t_cycle` output `$clog2(T_PER_M)`: current T index within the M-cycle.
- `m_start` output 1: first clock of an M-cycle.
- `m_commit` output 1: last clock of a completed M-cycle. The datapath writes registers on this edge.
- `sleep_req` input 1: enter sleep after the current M-cycle (HALT/STOP).
- `wake` input 1: leave sleep (level-sensitive).
- `sleeping` output 1: the sequencer is in SLEEP.
- `bus_timeout` output 1: one-clock pulse when a wait limit expires.
- `mem_addr` output `ADDR_W`: bus address.
- `mem_enable` output 1: bus access enable.
- `mem_write` output 1: bus write enable.
- `mem_data_out` output `DATA_W`: bus write data.
- `mem_data_in` input `DATA_W`: bus read data.
- `mem_ready` input 1: bus ready. Low inserts wait states.

## Operation

**State machine**
- States:
  - RUN: counting T-cycles.
  - WAIT: held at the last T-cycle until the bus is ready.
  - SLEEP: no M-cycles run.
- `T_LAST` is `T_PER_M-1`, or `T_PER_M/2-1` when speed is latched double.
- Speed is latched only on a `m_commit` edge, or on the SLEEP→RUN transition. A change of `double_speed` mid-M-cycle takes effect at the next M-cycle.

**RUN**
- `t_cycle` increments each clock.
- `m_start` = (`t_cycle` == 0).
- On the edge ending T0, the block latches `cpu_req`, `cpu_write`, `cpu_addr` and `cpu_wdata` into access registers.
- From T1 until the M-cycle completes:
  - `mem_enable` = latched req.
  - `mem_write` = latched req & latched write.
  - `mem_addr` and `mem_data_out` come from the latches.
- In T0:
  - `mem_enable` and `mem_write` are 0.
  - `mem_addr` and `mem_data_out` hold their previous values.

**Completion at `T_LAST`**
- The M-cycle completes when there is no latched access, or `mem_ready` = 1. In that clock, `m_commit` = 1.
- `mem_ready` is ignored when there is no latched access.
- If the access is pending and `mem_ready` = 0, the state goes to WAIT:
  - `t_cycle` holds at `T_LAST`.
  - `m_commit` = 0.
  - The wait counter increments each clock.
- In WAIT:
  - When `mem_ready` = 1, `m_commit` = 1 in that clock and the state returns to RUN at T0.
  - If the counter reaches `MAX_WAIT` without ready, `bus_timeout` and `m_commit` pulse together and the M-cycle completes.
  - A read completed by timeout returns `8'hFF` (open bus). A write completed by timeout is dropped.

**Read data**
- In a commit clock of a read, `cpu_rdata` is combinational:
  - `mem_data_in` for a normal read;
  - `8'hFF` for a read completed by timeout.
- At the same edge, that value is registered.
- At all other times, `cpu_rdata` shows the registered value.

**Sleep**
- `sleep_req` is sampled only in a `m_commit` clock. If it is 1 and `wake` is 0, the next state is SLEEP.
- If `sleep_req` and `wake` are both 1 at commit, the block stays in RUN (HALT with a pending interrupt).
- In SLEEP:
  - `t_cycle` = 0, `sleeping` = 1.
  - `m_start`, `m_commit`, `mem_enable` and `mem_write` are 0.
- When `wake` = 1 in SLEEP, the next clock is T0 of a new M-cycle in RUN.

## Timing

**Reset**
- `reset` high forces:
  - state RUN, `t_cycle` 0, wait counter 0;
  - speed normal;
  - all access latches 0, `cpu_rdata` 0;
  - `mem_addr` 0, `mem_data_out` 0.
- All 1-bit outputs are 0 while `reset` is high.
- The first clock after release is T0 with `m_start` = 1.
- Reset during WAIT or SLEEP aborts immediately. No `m_commit` or `bus_timeout` is emitted.

**Cycle counts**
- Minimum M-cycle length: `T_PER_M` clocks, or `T_PER_M/2` in double speed.
- Wait states add exactly N clocks for N clocks of `mem_ready` low.
- Latency from request to bus: `cpu_req` in T0 → `mem_enable` high in T1.

**Widths**
- The wait counter is `$clog2(MAX_WAIT+1)` bits and saturates; it never wraps.
- `t_cycle` counts `0..T_LAST`, then wraps to 0.

## Structure

**Shared package `cpu_bus_pkg`**
- `seq_state_e` with values SeqRun, SeqWait, SeqSleep.
- Constant `OPEN_BUS_DATA` = `8'hFF`.

**Implementation**
- Single module; no sub-module.
- `cpu` instantiates it and uses `m_commit` in place of `t_cycle == 3`.

## Test plan

1. Reset, then no requests → `m_start` at t=0 and `m_commit` at t=3, every 4 clocks; `mem_enable` stays 0.
2. Read 0xC000 with `mem_ready` = 1 and `mem_data_in` = 0x5A → `mem_enable` high in T1–T3; `cpu_rdata` = 0x5A in the commit clock and held afterwards.
3. Write 0xFF40 with data 0x91 and `mem_ready` low for 3 clocks → M-cycle lasts 7 clocks; `mem_write` is high throughout T1 to commit; `t_cycle` holds at 3.
4. Read with `mem_ready` stuck at 0 and `MAX_WAIT` = 15 → after 15 wait clocks, `bus_timeout` and `m_commit` pulse together and `cpu_rdata` = 0xFF.
5. Set `double_speed` at t=1 → the current M-cycle stays 4 clocks; the next M-cycle is 2 clocks with commit at t=1.
6. Cover three sleep cases:
   - `sleep_req` at commit → `sleeping` = 1 with no strobes for 10 clocks; then `wake` → T0 on the next clock.
   - `sleep_req` and `wake` together at commit → no sleep.
   - `reset` in WAIT → no commit, and outputs return to their reset values.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the SM83 M-cycle sequencer and bus interface.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    SeqRun   = 2'd0,
    SeqWait  = 2'd1,
    SeqSleep = 2'd2
  } seq_state_e;

  localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

endpackage

// File: rtl/cpu_bus_sequencer.sv
// M-cycle sequencer for the SM83 core: T-cycle counting, bus wait states with timeout,
// double-speed mode and HALT/STOP sleep. m_commit gates all datapath register writeback.
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int T_PER_M  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       double_speed,
  input  logic                       cpu_req,
  input  logic                       cpu_write,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic [$clog2(T_PER_M)-1:0] t_cycle,
  output logic                       m_start,
  output logic                       m_commit,
  input  logic                       sleep_req,
  input  logic                       wake,
  output logic                       sleeping,
  output logic                       bus_timeout,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_enable,
  output logic                       mem_write,
  output logic [DATA_W-1:0]          mem_data_out,
  input  logic [DATA_W-1:0]          mem_data_in,
  input  logic                       mem_ready
);

  localparam int TW = $clog2(T_PER_M);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0]     T_LAST_N = TW'(T_PER_M - 1);
  localparam logic [TW-1:0]     T_LAST_D = TW'(T_PER_M / 2 - 1);
  localparam logic [WW-1:0]     WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [DATA_W-1:0] OPEN_BUS = DATA_W'(OPEN_BUS_DATA);

  seq_state_e        state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              dbl_q, dbl_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              at_last;
  logic              commit;
  logic              timeout;
  logic              rd_commit;
  logic [DATA_W-1:0] rd_now;

  // A pending access in WAIT always has req_q set; mem_ready is ignored without one.
  assign at_last   = (t_q == (dbl_q ? T_LAST_D : T_LAST_N));
  assign timeout   = (state_q == SeqWait) && !mem_ready && (wait_q == WAIT_MAX);
  assign commit    = ((state_q == SeqRun) && at_last && (!req_q || mem_ready)) ||
                     ((state_q == SeqWait) && (mem_ready || (wait_q == WAIT_MAX)));
  assign rd_commit = commit && req_q && !wr_q;
  assign rd_now    = timeout ? OPEN_BUS : mem_data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SeqRun;
      t_q     <= '0;
      wait_q  <= '0;
      dbl_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wait_q  <= wait_d;
      dbl_q   <= dbl_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wait_d  = wait_q;
    dbl_d   = dbl_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      SeqRun: begin
        if (t_q == '0) begin
          req_d   = cpu_req;
          wr_d    = cpu_write;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end
        if (at_last && !commit) begin
          state_d = SeqWait;
          wait_d  = WW'(1);
        end else if (!at_last) begin
          t_d = t_q + TW'(1);
        end
      end
      SeqWait: begin
        if (!commit && (wait_q != WAIT_MAX)) begin
          wait_d = wait_q + WW'(1);
        end
      end
      SeqSleep: begin
        t_d = '0;
        if (wake) begin
          state_d = SeqRun;
          dbl_d   = double_speed;
        end
      end
      default: state_d = SeqRun;
    endcase

    // Speed and sleep decisions are only taken at an M-cycle boundary.
    if (commit) begin
      t_d     = '0;
      wait_d  = '0;
      dbl_d   = double_speed;
      state_d = (sleep_req && !wake) ? SeqSleep : SeqRun;
    end
    if (rd_commit) begin
      rdata_d = rd_now;
    end
  end

  always_comb begin
    m_start     = 1'b0;
    m_commit    = 1'b0;
    bus_timeout = 1'b0;
    sleeping    = 1'b0;
    mem_enable  = 1'b0;
    mem_write   = 1'b0;
    cpu_rdata   = rdata_q;
    if (!reset) begin
      m_start     = (state_q == SeqRun) && (t_q == '0);
      m_commit    = commit;
      bus_timeout = timeout;
      sleeping    = (state_q == SeqSleep);
      mem_enable  = (state_q != SeqSleep) && (t_q != '0) && req_q;
      mem_write   = (state_q != SeqSleep) && (t_q != '0) && req_q && wr_q;
      if (rd_commit) begin
        cpu_rdata = rd_now;
      end
    end
  end

  assign t_cycle      = t_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;

endmodule
